core_control_mp: RTL

//  Parametrised, multi-pass successor of the core controller. Sequences the memory controller
//  (input->mem, mem->reg) and the processing unit for one instruction. Loops TRANS/PROC until the MC

---
 rtl/core_control_mp_pkg.sv | 28 ++
 rtl/ctrl_watchdog.sv | 32 +++
 rtl/core_control_mp.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/core_control_mp_pkg.sv
// Shared state encoding, condition codes and error codes for the multi-pass core controller.
package core_control_mp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_TRANS,
        ST_PROC,
        ST_DONE,
        ST_ERROR
    } ctrl_state_t;

    // One-hot data-path routing seen by the memory controller.
    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_IN   = 3'b100;
    localparam logic [2:0] COND_MEM  = 3'b010;
    localparam logic [2:0] COND_REG  = 3'b001;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_OVR  = 2'b10;

    // States in which the controller waits on an external unit and the watchdog runs.
    function automatic logic wd_active(input ctrl_state_t s);
        return (s == ST_STORE) || (s == ST_TRANS) || (s == ST_PROC);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Per-state watchdog: counts cycles spent in a waiting state and flags expiry.
module ctrl_watchdog #(
    parameter int TMO_W       = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic ctrl_clk,
    input  logic ctrl_reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] CNT_MAX = '1;
    // cnt holds the number of completed cycles, so the TIMEOUT_CYC-th cycle sees TIMEOUT_CYC-1.
    localparam logic [TMO_W-1:0] LIMIT   = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [TMO_W-1:0] cnt;

    // Saturating cycle counter, zeroed on any state change or while idle.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && en && (cnt >= LIMIT);

endmodule

// File: rtl/core_control_mp.sv
// Multi-pass core controller: sequences MC transfers and processing passes for one instruction.
module core_control_mp
    import core_control_mp_pkg::*;
#(
    parameter int INST_W      = 3,
    parameter int LEN_W       = 6,
    parameter int PASS_W      = 4,
    parameter int MAX_PASSES  = 8,
    parameter int TMO_W       = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              ctrl_clk,
    input  logic              ctrl_reset,
    input  logic [INST_W-1:0] ctrl_instruction,
    input  logic              ctrl_valid_inst,
    input  logic              ctrl_valid_data,
    input  logic [LEN_W-1:0]  ctrl_data_in_size,
    output logic              ctrl_ready,
    output logic [2:0]        ctrl_data_contition,
    output logic [LEN_W-1:0]  mc_data_length,
    input  logic              mc_done,
    input  logic              mc_data_done,
    output logic [INST_W-1:0] procc_instruction,
    output logic              procc_start,
    input  logic              procc_done,
    output logic              ctrl_done,
    output logic [PASS_W-1:0] ctrl_pass_cnt,
    output logic              ctrl_error,
    output logic [1:0]        ctrl_err_code,
    input  logic              ctrl_err_clr
);

    localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_PASSES);
    localparam logic [PASS_W-1:0] PASS_SAT   = '1;

    ctrl_state_t       state;
    logic [INST_W-1:0] inst_q;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;

    // Watchdog restarts on every completion event that moves the FSM out of a waiting state.
    always_comb begin
        wd_en  = wd_active(state);
        wd_clr = 1'b0;
        unique case (state)
            ST_STORE: wd_clr = mc_done;
            ST_TRANS: wd_clr = mc_done;
            ST_PROC:  wd_clr = mc_data_done || procc_done;
            default:  wd_clr = 1'b0;
        endcase
    end

    ctrl_watchdog #(
        .TMO_W       (TMO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .ctrl_clk   (ctrl_clk),
        .ctrl_reset (ctrl_reset),
        .clr        (wd_clr),
        .en         (wd_en),
        .expired    (wd_expired)
    );

    // Controller FSM with all outputs registered; completion events take priority over timeout.
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state               <= ST_IDLE;
            ctrl_ready          <= 1'b1;
            ctrl_data_contition <= COND_NONE;
            mc_data_length      <= '0;
            inst_q              <= '0;
            procc_instruction   <= '0;
            procc_start         <= 1'b0;
            ctrl_done           <= 1'b0;
            ctrl_pass_cnt       <= '0;
            ctrl_error          <= 1'b0;
            ctrl_err_code       <= ERR_NONE;
        end else begin
            procc_start <= 1'b0;
            ctrl_done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ctrl_valid_inst && ctrl_valid_data && ctrl_ready) begin
                        mc_data_length <= ctrl_data_in_size;
                        inst_q         <= ctrl_instruction;
                        ctrl_ready     <= 1'b0;
                        ctrl_pass_cnt  <= '0;
                        if (ctrl_data_in_size != '0) begin
                            state               <= ST_STORE;
                            ctrl_data_contition <= COND_IN;
                        end else begin
                            state               <= ST_DONE;
                            ctrl_data_contition <= COND_NONE;
                            ctrl_done           <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (mc_done) begin
                        state               <= ST_TRANS;
                        ctrl_data_contition <= COND_MEM;
                    end else if (wd_expired) begin
                        state               <= ST_ERROR;
                        ctrl_data_contition <= COND_NONE;
                        ctrl_error          <= 1'b1;
                        ctrl_err_code       <= ERR_TMO;
                    end
                end
                ST_TRANS: begin
                    if (mc_done) begin
                        state               <= ST_PROC;
                        ctrl_data_contition <= COND_REG;
                        procc_instruction   <= inst_q;
                        procc_start         <= 1'b1;
                        if (ctrl_pass_cnt != PASS_SAT) begin
                            ctrl_pass_cnt <= ctrl_pass_cnt + PASS_W'(1);
                        end
                    end else if (wd_expired) begin
                        state               <= ST_ERROR;
                        ctrl_data_contition <= COND_NONE;
                        ctrl_error          <= 1'b1;
                        ctrl_err_code       <= ERR_TMO;
                    end
                end
                ST_PROC: begin
                    if (mc_data_done) begin
                        state               <= ST_DONE;
                        ctrl_data_contition <= COND_NONE;
                        ctrl_done           <= 1'b1;
                    end else if (procc_done) begin
                        if (ctrl_pass_cnt == PASS_LIMIT) begin
                            state               <= ST_ERROR;
                            ctrl_data_contition <= COND_NONE;
                            ctrl_error          <= 1'b1;
                            ctrl_err_code       <= ERR_OVR;
                        end else begin
                            state               <= ST_TRANS;
                            ctrl_data_contition <= COND_MEM;
                        end
                    end else if (wd_expired) begin
                        state               <= ST_ERROR;
                        ctrl_data_contition <= COND_NONE;
                        ctrl_error          <= 1'b1;
                        ctrl_err_code       <= ERR_TMO;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    ctrl_ready <= 1'b1;
                end
                ST_ERROR: begin
                    if (ctrl_err_clr) begin
                        state         <= ST_IDLE;
                        ctrl_ready    <= 1'b1;
                        ctrl_error    <= 1'b0;
                        ctrl_err_code <= ERR_NONE;
                        ctrl_pass_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
